// File: rtl/multicycle_ctrl_if.sv
// SRAM handshake bundle between the multicycle controller and the instruction/data memories.
// The controller is the master; the memory side is the slave.
interface multicycle_ctrl_if;
  logic inst_req;
  logic inst_rdy;
  logic data_req;
  logic data_wr;
  logic data_rdy;

  modport master (
    output inst_req,
    output data_req,
    output data_wr,
    input  inst_rdy,
    input  data_rdy
  );

  modport slave (
    input  inst_req,
    input  data_req,
    input  data_wr,
    output inst_rdy,
    output data_rdy
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: IF/ID/EXE/MEM/WB with SRAM handshakes, a retire counter and a sticky timeout error.
// Strobes are decoded combinationally from the state register and the rdy inputs, and are forced low during reset.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_ctrl_if.master        mem,
  input  logic                     dec_is_br_i,
  input  logic                     dec_is_ld_i,
  input  logic                     dec_is_st_i,
  input  logic                     dec_has_wb_i,
  output logic [2:0]               state_o,
  output logic                     ir_we_o,
  output logic                     rf_we_o,
  output logic                     pc_we_o,
  output logic                     retire_o,
  output logic [31:0]              retire_cnt_o,
  output logic                     err_o
);

  localparam int unsigned CntW = 8;
  localparam int unsigned StW  = 3;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  localparam logic [StW-1:0] S_IF  = 3'd0;
  localparam logic [StW-1:0] S_ID  = 3'd1;
  localparam logic [StW-1:0] S_EXE = 3'd2;
  localparam logic [StW-1:0] S_MEM = 3'd3;
  localparam logic [StW-1:0] S_WB  = 3'd4;
  localparam logic [StW-1:0] S_ERR = 3'd5;

  logic [StW-1:0]  state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            cls_ld_q, cls_ld_d;
  logic            cls_st_q, cls_st_d;
  logic            cls_wb_q, cls_wb_d;
  logic [31:0]     retire_cnt_q;
  logic            err_q;

  logic retire_c;
  logic inst_req_c;
  logic ir_we_c;
  logic data_req_c;
  logic data_wr_c;
  logic rf_we_c;

  // Next-state, wait-counter and strobe decode
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cls_ld_d   = cls_ld_q;
    cls_st_d   = cls_st_q;
    cls_wb_d   = cls_wb_q;
    retire_c   = 1'b0;
    inst_req_c = 1'b0;
    ir_we_c    = 1'b0;
    data_req_c = 1'b0;
    data_wr_c  = 1'b0;
    rf_we_c    = 1'b0;

    case (state_q)
      S_IF: begin
        inst_req_c = 1'b1;
        if (mem.inst_rdy) begin
          ir_we_c = 1'b1;
          state_d = S_ID;
        end else if (wait_q == TimeoutVal) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      S_ID: begin
        // Load wins when both load and store are decoded
        cls_ld_d = dec_is_ld_i;
        cls_st_d = dec_is_st_i & ~dec_is_ld_i;
        cls_wb_d = dec_has_wb_i;
        if (dec_is_br_i) begin
          retire_c = 1'b1;
          state_d  = S_IF;
          wait_d   = '0;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (cls_ld_q || cls_st_q) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (cls_wb_q) begin
          state_d = S_WB;
        end else begin
          retire_c = 1'b1;
          state_d  = S_IF;
          wait_d   = '0;
        end
      end
      S_MEM: begin
        data_req_c = 1'b1;
        data_wr_c  = cls_st_q;
        if (mem.data_rdy) begin
          if (cls_ld_q) begin
            state_d = S_WB;
          end else begin
            retire_c = 1'b1;
            state_d  = S_IF;
            wait_d   = '0;
          end
        end else if (wait_q == TimeoutVal) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        retire_c = 1'b1;
        state_d  = S_IF;
        wait_d   = '0;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IF;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IF;
      wait_q       <= '0;
      cls_ld_q     <= 1'b0;
      cls_st_q     <= 1'b0;
      cls_wb_q     <= 1'b0;
      retire_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cls_ld_q <= cls_ld_d;
      cls_st_q <= cls_st_d;
      cls_wb_q <= cls_wb_d;
      if (retire_c) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem.inst_req = inst_req_c & ~reset;
  assign mem.data_req = data_req_c & ~reset;
  assign mem.data_wr  = data_wr_c  & ~reset;
  assign ir_we_o      = ir_we_c    & ~reset;
  assign rf_we_o      = rf_we_c    & ~reset;
  assign pc_we_o      = retire_c   & ~reset;
  assign retire_o     = retire_c   & ~reset;
  assign state_o      = state_q;
  assign retire_cnt_o = retire_cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle expected records are queued as stimulus is planned,
// then popped one per clock and compared against the DUT.
module tb_multicycle_ctrl;
  localparam int unsigned TO = 15;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_ERR = 3'd5;

  typedef struct packed {
    logic       irdy, drdy, br, ld, st, wb;
    logic [2:0] st_e;
    logic       ireq, irwe, dreq, dwr, rfwe, ret, err;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_is_br, dec_is_ld, dec_is_st, dec_has_wb;
  logic [2:0]  state;
  logic        ir_we, rf_we, pc_we, retire, err;
  logic [31:0] retire_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cnt_m  = '0;
  cyc_t        sb[$];

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (mem_if),
    .dec_is_br_i  (dec_is_br),
    .dec_is_ld_i  (dec_is_ld),
    .dec_is_st_i  (dec_is_st),
    .dec_has_wb_i (dec_has_wb),
    .state_o      (state),
    .ir_we_o      (ir_we),
    .rf_we_o      (rf_we),
    .pc_we_o      (pc_we),
    .retire_o     (retire),
    .retire_cnt_o (retire_cnt),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic cyc_t mk(input logic [2:0] s, input logic ireq, irwe, dreq, dwr, rfwe, ret);
    cyc_t c;
    c.irdy = 1'($urandom_range(0, 1));
    c.drdy = 1'($urandom_range(0, 1));
    c.br   = 1'($urandom_range(0, 1));
    c.ld   = 1'($urandom_range(0, 1));
    c.st   = 1'($urandom_range(0, 1));
    c.wb   = 1'($urandom_range(0, 1));
    c.st_e = s;
    c.ireq = ireq; c.irwe = irwe; c.dreq = dreq; c.dwr = dwr;
    c.rfwe = rfwe; c.ret = ret; c.err = 1'b0;
    return c;
  endfunction

  // Plan one instruction from the architectural rules; iw/dw are rdy-low cycles before the handshake.
  task automatic gen_instr(input logic br, ld, st, wb, input int iw, dw);
    cyc_t c;
    logic isld, isst;
    isld = ld;
    isst = st & ~ld;
    for (int i = 0; i < iw; i++) begin
      c = mk(S_IF, 1, 0, 0, 0, 0, 0); c.irdy = 1'b0; sb.push_back(c);
    end
    c = mk(S_IF, 1, 1, 0, 0, 0, 0); c.irdy = 1'b1; sb.push_back(c);
    c = mk(S_ID, 0, 0, 0, 0, 0, br);
    c.br = br; c.ld = ld; c.st = st; c.wb = wb; sb.push_back(c);
    if (br) return;
    if (isld || isst) begin
      sb.push_back(mk(S_EXE, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < dw; i++) begin
        c = mk(S_MEM, 0, 0, 1, isst, 0, 0); c.drdy = 1'b0; sb.push_back(c);
      end
      c = mk(S_MEM, 0, 0, 1, isst, 0, isst); c.drdy = 1'b1; sb.push_back(c);
      if (isld) sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1));
    end else if (wb) begin
      sb.push_back(mk(S_EXE, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1));
    end else begin
      sb.push_back(mk(S_EXE, 0, 0, 0, 0, 0, 1));
    end
  endtask

  // Entered just after a falling edge; pops up to n records, one per cycle.
  task automatic run_cycles(input string name, input int n);
    cyc_t c;
    logic [10:0] got, exp;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      c = sb.pop_front();
      mem_if.inst_rdy = c.irdy; mem_if.data_rdy = c.drdy;
      dec_is_br = c.br; dec_is_ld = c.ld; dec_is_st = c.st; dec_has_wb = c.wb;
      #1;
      got = {state, mem_if.inst_req, ir_we, mem_if.data_req, mem_if.data_wr, rf_we, pc_we, retire, err};
      exp = {c.st_e, c.ireq, c.irwe, c.dreq, c.dwr, c.rfwe, c.ret, c.ret, c.err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d {state,ireq,irwe,dreq,dwr,rfwe,pcwe,ret,err} got=%b exp=%b", name, k, got, exp);
      end
      checks++;
      if (retire_cnt !== cnt_m) begin
        errors++;
        $display("FAIL %s cyc%0d retire_cnt got=%h exp=%h", name, k, retire_cnt, cnt_m);
      end
      if (c.ret) cnt_m = cnt_m + 32'd1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_if.inst_rdy = 1'b0; mem_if.data_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt_m = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    mem_if.inst_rdy = 1'b0; mem_if.data_rdy = 1'b0;
    dec_is_br = 1'b0; dec_is_ld = 1'b0; dec_is_st = 1'b0; dec_has_wb = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_if.inst_rdy = 1'b1; mem_if.data_rdy = 1'b1;
    #1;
    checks++;
    if ({state, mem_if.inst_req, ir_we, mem_if.data_req, mem_if.data_wr, rf_we, pc_we, retire, err} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got state=%0d ireq=%b irwe=%b dreq=%b dwr=%b rfwe=%b pcwe=%b ret=%b err=%b exp all 0",
               state, mem_if.inst_req, ir_we, mem_if.data_req, mem_if.data_wr, rf_we, pc_we, retire, err);
    end
    checks++;
    if (retire_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got=%h exp=0", retire_cnt);
    end
    mem_if.inst_rdy = 1'b0; mem_if.data_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_if.inst_req !== 1'b1) begin
      errors++; $display("FAIL reset_release_ireq got=%b exp=1", mem_if.inst_req);
    end
    do_reset();
  endtask

  task automatic test_load();
    gen_instr(0, 1, 0, 1, 0, 0);
    run_cycles("load", 100);
  endtask

  task automatic test_store();
    gen_instr(0, 0, 1, 0, 0, 3);
    run_cycles("store_wait3", 100);
  endtask

  task automatic test_branch();
    gen_instr(1, 0, 0, 0, 0, 0);
    run_cycles("branch", 100);
  endtask

  task automatic test_alu();
    gen_instr(0, 0, 0, 1, 1, 0);
    gen_instr(0, 0, 0, 0, 2, 0);
    run_cycles("alu", 100);
  endtask

  task automatic test_ld_st_both();
    gen_instr(0, 1, 1, 0, 0, 2);
    run_cycles("ld_st_both", 100);
  endtask

  task automatic test_timeout_edge();
    do_reset();
    gen_instr(0, 0, 0, 1, TO, 0);
    gen_instr(0, 1, 0, 1, 0, TO);
    gen_instr(0, 0, 1, 0, 0, TO);
    run_cycles("timeout_edge", 200);
  endtask

  task automatic test_back_to_back();
    int kind;
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: gen_instr(1, 0, 0, 0, $urandom_range(0, 3), 0);
        1: gen_instr(0, 0, 0, 1, $urandom_range(0, 3), 0);
        2: gen_instr(0, 0, 0, 0, $urandom_range(0, 3), 0);
        3: gen_instr(0, 1, 0, 1, $urandom_range(0, 3), $urandom_range(0, 4));
        4: gen_instr(0, 0, 1, 0, $urandom_range(0, 3), $urandom_range(0, 4));
        default: gen_instr(0, 1, 1, 1, $urandom_range(0, 3), $urandom_range(0, 4));
      endcase
    end
    run_cycles("back_to_back", 1000);
  endtask

  task automatic test_wrap();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    gen_instr(1, 0, 0, 0, 0, 0);
    run_cycles("wrap", 100);
    #1;
    checks++;
    if (retire_cnt !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_final retire_cnt got=%h exp=00000000", retire_cnt);
    end
  endtask

  task automatic test_reset_mid();
    gen_instr(0, 1, 0, 1, 0, 5);
    run_cycles("reset_mid_pre", 4);
    reset = 1'b1;
    mem_if.data_rdy = 1'b1;
    #1;
    checks++;
    if ({state, retire, pc_we, rf_we, mem_if.data_req} !== {S_MEM, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid_strobes got state=%0d ret=%b pcwe=%b rfwe=%b dreq=%b exp state=3 strobes 0",
               state, retire, pc_we, rf_we, mem_if.data_req);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_if.inst_rdy = 1'b0; mem_if.data_rdy = 1'b0;
    sb.delete();
    cnt_m = '0;
    #1;
    checks++;
    if ({state, mem_if.inst_req, retire, retire_cnt} !== {S_IF, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_mid_after got state=%0d ireq=%b ret=%b cnt=%h exp state=0 ireq=1 ret=0 cnt=0",
               state, mem_if.inst_req, retire, retire_cnt);
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_timeout();
    cyc_t c;
    do_reset();
    for (int i = 0; i <= int'(TO); i++) begin
      c = mk(S_IF, 1, 0, 0, 0, 0, 0); c.irdy = 1'b0; sb.push_back(c);
    end
    for (int i = 0; i < 4; i++) begin
      c = mk(S_ERR, 0, 0, 0, 0, 0, 0); c.irdy = 1'b1; c.err = 1'b1; sb.push_back(c);
    end
    run_cycles("timeout", 100);
    do_reset();
    #1;
    checks++;
    if ({state, err, mem_if.inst_req} !== {S_IF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_reset got state=%0d err=%b ireq=%b exp state=0 err=0 ireq=1", state, err, mem_if.inst_req);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_alu();
    test_ld_st_both();
    test_timeout_edge();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
